// File: rtl/demux_write_bank.sv
// rtl/demux_write_bank.sv - write demultiplexer into a register bank with one pending stage and read bypass
// A request is captured into the pending stage, then committed one edge later; reads see the pending value first.
module demux_write_bank #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [DEPTH-1:0]           wr_strobe,
  input  logic [$clog2(DEPTH)-1:0]   rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  output logic [DEPTH*WIDTH-1:0]     bank_out
);

  localparam int SELW = $clog2(DEPTH);

  logic              r_pend_valid;
  logic [SELW-1:0]   r_pend_sel;
  logic [WIDTH-1:0]  r_pend_data;
  logic [WIDTH-1:0]  r_bank [DEPTH];

  logic              w_drop;
  logic              w_rd_zero;
  logic              w_rd_bypass;
  logic [DEPTH-1:0]  w_strobe;

  // Writes to the hardwired zero register are discarded before they can strobe, bypass or commit.
  assign w_drop = (ZERO_REG != 0) && (wr_sel == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_sel   <= '0;
      r_pend_data  <= '0;
    end else begin
      r_pend_valid <= wr_en && !w_drop;
      r_pend_sel   <= wr_sel;
      r_pend_data  <= wr_data;
    end
  end

  always_comb begin
    w_strobe = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_strobe[i] = r_pend_valid && (r_pend_sel == SELW'(i));
    end
  end

  assign wr_strobe = w_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_strobe[i]) begin
          r_bank[i] <= r_pend_data;
        end
      end
    end
  end

  assign w_rd_zero   = (ZERO_REG != 0) && (rd_sel == '0);
  assign w_rd_bypass = r_pend_valid && (r_pend_sel == rd_sel);

  always_comb begin
    rd_data = r_bank[rd_sel];
    if (w_rd_zero) begin
      rd_data = '0;
    end else if (w_rd_bypass) begin
      rd_data = r_pend_data;
    end
  end

  always_comb begin
    bank_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bank_out[i*WIDTH +: WIDTH] = r_bank[i];
    end
    if (ZERO_REG != 0) begin
      bank_out[WIDTH-1:0] = '0;
    end
  end

endmodule

// File: tb/tb_demux_write_bank.sv
// tb/tb_demux_write_bank.sv - randomized and directed check of demux_write_bank against a bank model
module tb_demux_write_bank;

  localparam int W = 32;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [2:0]     wr_sel;
  logic [W-1:0]   wr_data;
  logic [D-1:0]   wr_strobe;
  logic [2:0]     rd_sel;
  logic [W-1:0]   rd_data;
  logic [D*W-1:0] bank_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: committed contents plus at most one outstanding request.
  logic [W-1:0] m_bank [D];
  bit           m_pv;
  int           m_ps;
  logic [W-1:0] m_pd;

  demux_write_bank #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_strobe(wr_strobe), .rd_sel(rd_sel), .rd_data(rd_data), .bank_out(bank_out)
  );

  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_bank[i] = '0;
    m_pv = 0;
    m_ps = 0;
    m_pd = '0;
  endtask

  task automatic model_edge(input bit en, input int sel, input logic [W-1:0] data);
    if (m_pv) m_bank[m_ps] = m_pd;
    m_pv = en && (sel != 0);
    m_ps = sel;
    m_pd = data;
  endtask

  function automatic logic [W-1:0] exp_rd(input int r);
    if (r == 0) return '0;
    if (m_pv && m_ps == r) return m_pd;
    return m_bank[r];
  endfunction

  function automatic logic [D*W-1:0] exp_bank_out();
    logic [D*W-1:0] v;
    v = '0;
    for (int i = 1; i < D; i++) v[i*W +: W] = m_bank[i];
    return v;
  endfunction

  task automatic check_state(input string tag);
    logic [D-1:0] s;
    s = m_pv ? (D'(1) << m_ps) : '0;
    check_eq({tag, "_strobe"}, wr_strobe, s);
    check_eq({tag, "_bank"}, bank_out, exp_bank_out());
    for (int r = 0; r < D; r++) begin
      rd_sel = 3'(r);
      #1;
      check_eq($sformatf("%s_rd%0d", tag, r), rd_data, exp_rd(r));
    end
  endtask

  task automatic cycle(input string tag, input bit en, input int sel, input logic [W-1:0] data);
    wr_en   = en;
    wr_sel  = 3'(sel);
    wr_data = data;
    @(posedge clk);
    model_edge(en, sel, data);
    #1;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;
    model_reset();
    #50;
    check_eq("reset_strobe", wr_strobe, '0);
    check_eq("reset_bank", bank_out, '0);
    check_eq("reset_rd", rd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write
    cycle("w3", 1, 3, 32'hDEADBEEF);
    check_eq("w3_strobe_lit", wr_strobe, 8'b0000_1000);
    rd_sel = 3'd3; #1;
    check_eq("w3_bypass_lit", rd_data, 32'hDEADBEEF);
    cycle("w3_idle", 0, 0, '0);
    check_eq("w3_commit_lit", bank_out[3*W +: W], 32'hDEADBEEF);
    check_eq("w3_strobe_off", wr_strobe, '0);

    // Back-to-back same index
    cycle("b2b_a", 1, 5, 32'h11);
    rd_sel = 3'd5; #1;
    check_eq("b2b_rd_a", rd_data, 32'h11);
    cycle("b2b_b", 1, 5, 32'h22);
    rd_sel = 3'd5; #1;
    check_eq("b2b_rd_b", rd_data, 32'h22);
    cycle("b2b_idle", 0, 0, '0);
    check_eq("b2b_commit", bank_out[5*W +: W], 32'h22);

    // Zero register write is dropped
    cycle("zero", 1, 0, 32'hFFFFFFFF);
    check_eq("zero_strobe", wr_strobe, '0);
    rd_sel = 3'd0; #1;
    check_eq("zero_rd", rd_data, '0);
    cycle("zero_idle", 0, 0, '0);
    check_eq("zero_bank", bank_out[W-1:0], '0);

    // Reset while a write is pending
    cycle("pend", 1, 2, 32'hA5);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_mid_strobe", wr_strobe, '0);
    check_eq("rst_mid_bank", bank_out, '0);
    check_eq("rst_mid_rd", rd_data, '0);
    #2 rst_n = 1'b1;
    cycle("rst_after", 0, 0, '0);
    check_eq("rst_reg2", bank_out[2*W +: W], '0);
    check_eq("rst_strobe", wr_strobe, '0);

    // Sweep
    for (int i = 1; i < D; i++) cycle($sformatf("sweep%0d", i), 1, i, W'(i) * 32'h01010101);
    cycle("sweep_idle", 0, 0, '0);
    for (int i = 1; i < D; i++)
      check_eq($sformatf("sweep_lit%0d", i), bank_out[i*W +: W], W'(i) * 32'h01010101);

    // Mid-cycle reset with bank preloaded
    #5 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_pre_bank", bank_out, '0);
    check_eq("rst_pre_strobe", wr_strobe, '0);
    rd_sel = 3'd4; #1;
    check_eq("rst_pre_rd", rd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), int'($urandom_range(0, D - 1)), $urandom);
    end
    cycle("rnd_end", 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
